// File: rtl/key_phv_fifo.sv
// PHV + masked-key decoupling FIFO between the key extractor and the lookup stage.
// First-word-fall-through head, early ready_out for in-flight skid, sticky drop/mispair flags.
module key_phv_fifo #(
    parameter int unsigned PHV_LEN = 4*8*64+256,
    parameter int unsigned KEY_LEN = 8*32+1,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned SKID    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PHV_LEN-1:0]         phv_in,
    input  logic                       phv_valid_in,
    input  logic [KEY_LEN-1:0]         key_in,
    input  logic                       key_valid_in,
    output logic                       ready_out,
    output logic [PHV_LEN-1:0]         phv_out,
    output logic                       phv_valid_out,
    output logic [KEY_LEN-1:0]         key_out,
    output logic                       key_valid_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow_err,
    output logic                       mismatch_err,
    input  logic                       err_clear
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PHV_LEN-1:0] phv;
        logic [KEY_LEN-1:0] key;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               head_valid;
    logic               ready_q;
    logic               ovf_q;
    logic               mis_q;
    logic               both_valid;
    logic               full;
    logic               pop;
    logic               push;
    logic               ovf_event;
    logic               mis_event;

    // Handshake decode and next count from the registered state.
    always_comb begin
        both_valid = phv_valid_in && key_valid_in;
        full       = (count == CNT_W'(DEPTH));
        pop        = head_valid && ready_in;
        push       = both_valid && (!full || pop);
        ovf_event  = both_valid && full && !pop;
        mis_event  = phv_valid_in ^ key_valid_in;
        count_nxt  = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, count and the registered flags derived from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            ready_q    <= 1'b1;
            ovf_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_nxt;
            head_valid <= (count_nxt != '0);
            ready_q    <= (count_nxt < CNT_W'(DEPTH - SKID));
            // A new event in the same cycle as err_clear keeps the flag set.
            if (ovf_event)      ovf_q <= 1'b1;
            else if (err_clear) ovf_q <= 1'b0;
            if (mis_event)      mis_q <= 1'b1;
            else if (err_clear) mis_q <= 1'b0;
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{phv: phv_in, key: key_in};
    end

    assign head          = mem[rd_ptr];
    assign phv_out       = head_valid ? head.phv : '0;
    assign key_out       = head_valid ? head.key : '0;
    assign phv_valid_out = head_valid;
    assign key_valid_out = head_valid;
    assign ready_out     = ready_q;
    assign occupancy     = count;
    assign overflow_err  = ovf_q;
    assign mismatch_err  = mis_q;

endmodule

// File: tb/tb_key_phv_fifo.sv
// Bench for key_phv_fifo: vector table for the single-entry/fill/overflow/mismatch cases,
// scripted sequences for full-rate wrap and asynchronous reset, queue scoreboard for data.
module tb_key_phv_fifo;

    localparam int unsigned PHV_LEN = 4*8*64+256;
    localparam int unsigned KEY_LEN = 8*32+1;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned SKID    = 3;

    logic               clk;
    logic               rst_n;
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid_in;
    logic [KEY_LEN-1:0] key_in;
    logic               key_valid_in;
    logic               ready_out;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;
    logic [KEY_LEN-1:0] key_out;
    logic               key_valid_out;
    logic               ready_in;
    logic [3:0]         occupancy;
    logic               overflow_err;
    logic               mismatch_err;
    logic               err_clear;

    key_phv_fifo #(
        .PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .DEPTH(DEPTH), .SKID(SKID)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .key_in(key_in), .key_valid_in(key_valid_in),
        .ready_out(ready_out),
        .phv_out(phv_out), .phv_valid_out(phv_valid_out),
        .key_out(key_out), .key_valid_out(key_valid_out),
        .ready_in(ready_in), .occupancy(occupancy),
        .overflow_err(overflow_err), .mismatch_err(mismatch_err),
        .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pv;
        logic       kv;
        logic [7:0] tag;
        logic       rdy;
        logic       clr;
        logic [3:0] occ;
        logic       rdo;
        logic       ovf;
        logic       mis;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    logic       m_ovf;
    logic       m_mis;
    int         vectors;
    int         miscompares;

    function automatic vec_t v(logic pv, logic kv, logic [7:0] tag, logic rdy, logic clr,
                               logic [3:0] occ, logic rdo, logic ovf, logic mis);
        vec_t r;
        r.pv = pv; r.kv = kv; r.tag = tag; r.rdy = rdy; r.clr = clr;
        r.occ = occ; r.rdo = rdo; r.ovf = ovf; r.mis = mis;
        return r;
    endfunction

    function automatic logic [PHV_LEN-1:0] mk_phv(logic [7:0] tag);
        logic [7:0] b;
        b = 8'hA5 ^ tag;
        return {(PHV_LEN/8){b}};
    endfunction

    function automatic logic [KEY_LEN-1:0] mk_key(logic [7:0] tag);
        logic [7:0] b;
        b = 8'h1F ^ tag;
        return {tag[0], {((KEY_LEN-1)/8){b}}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output; head data always comes from the scoreboard queue.
    task automatic check_all(input logic [3:0] occ, input logic rdo, input logic ovf, input logic mis);
        logic [PHV_LEN-1:0] ep;
        logic [KEY_LEN-1:0] ek;
        ep = '0;
        ek = '0;
        if (sb.size() != 0) begin
            ep = mk_phv(sb[0]);
            ek = mk_key(sb[0]);
        end
        chk("occupancy", 64'(occupancy), 64'(occ));
        chk("ready_out", 64'(ready_out), 64'(rdo));
        chk("phv_valid_out", 64'(phv_valid_out), 64'(sb.size() != 0));
        chk("key_valid_out", 64'(key_valid_out), 64'(sb.size() != 0));
        chk("overflow_err", 64'(overflow_err), 64'(ovf));
        chk("mismatch_err", 64'(mismatch_err), 64'(mis));
        vectors++;
        if (phv_out !== ep || key_out !== ek) begin
            miscompares++;
            $display("FAIL head_data: got phv %0h key %0h expected phv %0h key %0h at %0t",
                     phv_out[63:0], key_out[63:0], ep[63:0], ek[63:0], $time);
        end
    endtask

    // Drive one cycle of stimulus and advance the scoreboard across the next edge.
    task automatic drive(input logic pv, input logic kv, input logic [7:0] tag,
                         input logic rdy, input logic clr);
        logic pop;
        logic push;
        phv_valid_in = pv;
        key_valid_in = kv;
        phv_in       = mk_phv(tag);
        key_in       = mk_key(tag);
        ready_in     = rdy;
        err_clear    = clr;
        pop  = (sb.size() != 0) && rdy;
        push = pv && kv && ((sb.size() < DEPTH) || pop);
        if (pv && kv && sb.size() == DEPTH && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (pv != kv) m_mis = 1'b1;
        else if (clr) m_mis = 1'b0;
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic step_model(input logic pv, input logic kv, input logic [7:0] tag,
                              input logic rdy, input logic clr);
        drive(pv, kv, tag, rdy, clr);
        check_all(4'(sb.size()), sb.size() < (DEPTH - SKID), m_ovf, m_mis);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        m_ovf        = 1'b0;
        m_mis        = 1'b0;
        rst_n        = 1'b0;
        phv_in       = '0;
        key_in       = '0;
        phv_valid_in = 1'b0;
        key_valid_in = 1'b0;
        ready_in     = 1'b0;
        err_clear    = 1'b0;

        // Single entry, fill/ready_out threshold, overflow and drain, mismatch handling.
        tbl.push_back(v(1, 1, 8'h00, 1, 0, 4'd1, 1, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 4'd0, 1, 0, 0));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(v(1, 1, 8'(i), 0, 0, 4'(i), i < 5, 0, 0));
        tbl.push_back(v(1, 1, 8'h09, 0, 0, 4'd8, 0, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 4'd8, 0, 1, 0));
        for (int i = 7; i >= 0; i--)
            tbl.push_back(v(0, 0, 8'h00, 1, 0, 4'(i), i < 5, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 4'd0, 1, 0, 0));
        tbl.push_back(v(1, 0, 8'h33, 1, 0, 4'd0, 1, 0, 1));
        tbl.push_back(v(1, 0, 8'h34, 1, 1, 4'd0, 1, 0, 1));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 4'd0, 1, 0, 0));
        tbl.push_back(v(0, 1, 8'h35, 0, 0, 4'd0, 1, 0, 1));
        tbl.push_back(v(1, 1, 8'h36, 0, 1, 4'd1, 1, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 4'd0, 1, 0, 0));

        #12;
        check_all(4'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all(4'd0, 1'b1, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].pv, tbl[i].kv, tbl[i].tag, tbl[i].rdy, tbl[i].clr);
            check_all(tbl[i].occ, tbl[i].rdo, tbl[i].ovf, tbl[i].mis);
        end

        // Full-rate push and pop at count==DEPTH across several pointer wraps.
        for (int i = 0; i < 8; i++) step_model(1, 1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            step_model(1, 1, 8'(8'h60 + i), 1, 0);
            chk("full_rate_occ", 64'(occupancy), 64'd8);
        end
        for (int i = 0; i < 8; i++) step_model(0, 0, 8'h00, 1, 0);

        // Asynchronous reset with six entries queued and a sticky flag set.
        for (int i = 0; i < 6; i++) step_model(1, 1, 8'(8'h80 + i), 0, 0);
        step_model(1, 0, 8'h00, 0, 0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_mis = 1'b0;
        #1;
        check_all(4'd0, 1'b1, 1'b0, 1'b0);
        phv_valid_in = 1'b0;
        key_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step_model(1, 1, 8'hC7, 0, 0);
        step_model(0, 0, 8'h00, 0, 0);
        step_model(0, 0, 8'h00, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
